uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single transmitter of `uart_top` among `NREQ` byte requesters. Each requester presents a byte plus its own parity configuration through a valid/ready handshake. The arbiter latches the winning byte, drives `tx_start`/`tx_data`/`par_en`/`par_ty` into `uart_top`, and tracks `tx_busy` through the frame. It then enforces an inter-frame gap before granting the next requester. It sits between the host-side message sources and `uart_top`.

## Interface
- `NREQ`, 4: number of requesters; 2 to 8.
- `START_TIMEOUT`, 64: cycles allowed in START for `tx_busy` to rise.
- `GAP_CYCLES`, 16: idle cycles after each frame; 0 is legal.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NREQ: bit i set means requester i has a byte pending.
- `req_data` in 8*NREQ: byte of requester i on bits [8i+7:8i].
- `req_par_en` in NREQ: parity enable for requester i's frame.
- `req_par_ty` in NREQ: parity type for requester i's frame (0 even, 1 odd).
- `req_ready` out NREQ: one-hot, one-cycle accept pulse.
- `tx_start` out 1: start request to `uart_top`.
- `tx_data` out 8: byte to `uart_top`.
- `par_en` out 1: parity enable to `uart_top`.
- `par_ty` out 1: parity type to `uart_top`.
- `tx_busy` in 1: transmitter busy, from `uart_top`.
- `grant_id` out clog2(NREQ): index of the current or last granted requester.
- `arb_busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a frame completes.
- `timeout_err` out 1: one-cycle pulse when a start is abandoned.

## Operation
- States are IDLE, START, WAIT_DONE and GAP.
- **IDLE**
  - Accept happens when any `req_valid` is set and the sampled `tx_busy` is 0.
  - The winner is the first set `req_valid` bit, searching from `(last+1) mod NREQ` upward with wrap.
  - `last` resets to NREQ-1, so requester 0 has first priority after reset.
  - On accept in cycle T: `req_ready[g]`=1 combinationally in cycle T.
  - Also on accept: `req_data[g]`, `req_par_en[g]` and `req_par_ty[g]` are registered into `tx_data`, `par_en` and `par_ty`.
  - Also on accept: `grant_id`<=g, `last`<=g, next state START.
  - If `tx_busy` is 1 in IDLE (external activity), nothing is accepted.
- **START**
  - `tx_start`=1 and the timeout counter increments each cycle.
  - When `tx_busy` is sampled 1, next state is WAIT_DONE and `tx_start` deasserts from the next cycle.
  - When the counter reaches `START_TIMEOUT` with `tx_busy` still 0: pulse `timeout_err`, drop `tx_start`, go to IDLE.
  - A timed-out byte is discarded. `last` already points at g, so fairness advances.
- **WAIT_DONE**
  - When `tx_busy` is sampled 0: pulse `done` with `grant_id`=g.
  - Then go to GAP, or to IDLE if `GAP_CYCLES`=0.
- **GAP**
  - Counts `GAP_CYCLES` cycles, then goes to IDLE. `req_ready` stays 0 throughout.
- `tx_data`, `par_en` and `par_ty` hold their values from accept until the next accept. They never change while `tx_busy`=1.
- Requesters that deassert `req_valid` before being granted are simply skipped. A byte is owned by the arbiter only after `req_ready`.
- Counters are sized clog2 of the respective parameter plus 1. They clear on every state entry.

## Timing
- Reset values: `req_ready`=0, `tx_start`=0, `tx_data`=0, `par_en`=0, `par_ty`=0, `grant_id`=0, `arb_busy`=0, `done`=0, `timeout_err`=0. State is IDLE and `last`=NREQ-1.
- Accept in cycle T gives `tx_start`=1 from T+1.
- `tx_busy` first sampled high in cycle B gives `tx_start`=0 from B+1.
- `tx_busy` sampled low in WAIT_DONE at cycle E gives `done`=1 in E+1.
- The next accept is no earlier than E+1+`GAP_CYCLES`.
- Timeout: `timeout_err` pulses in the cycle after the `START_TIMEOUT`-th START cycle.
- Reset asserted in any state: all outputs take their reset values the following cycle and the latched byte is lost.
  - If `tx_busy` is still high after reset, IDLE waits for it to fall before accepting.
- Simultaneous requests: exactly one `req_ready` bit is ever high.

## Test plan
- **Single byte.** Loopback `uart_top`; req0 sends 0xAF with par_en=1, par_ty=0.
  - Required: `req_ready[0]` pulses once, then `tx_start` until `tx_busy`.
  - Required: `done` with `grant_id`=0, and `uart_top` rx_data=0xAF with no parity or framing error.
- **Round-robin.** All four requesters are held valid with bytes 0x10, 0x11, 0x12, 0x13.
  - Required: bytes are transmitted in order 0x10, 0x11, 0x12, 0x13, 0x10.
  - Required: consecutive `tx_start` rises are at least one frame plus 16 cycles apart.
- **Fairness.** req0 is continuously valid; req2 is raised mid-frame of req0.
  - Required: the next grant is 2, then 0.
- **Per-requester parity.** req1 uses par_en=1, par_ty=1 with 0x3C; req3 uses par_en=0 with 0x55.
  - Required: `par_en`/`par_ty` read 1/1, then 0/x, stable across each `tx_busy` window.
  - Required: the receiver reports no parity error.
- **Timeout.** `tx_busy` is forced to 0; req0 sends 0x01 and req1 sends 0x02.
  - Required: `timeout_err` pulses 64 cycles after `tx_start` rises, then req1 is granted.
- **Reset mid-frame.** Assert `rst` for 1 cycle during WAIT_DONE.
  - Required: `tx_start`=0, `arb_busy`=0, `grant_id`=0 next cycle.
  - Required: with `tx_busy` still 1, no `req_ready` until it falls; then req0 wins first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources,
// with start timeout and a fixed inter-frame gap.
module uart_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int START_TIMEOUT = 64,
    parameter int GAP_CYCLES    = 16,
    localparam int IDW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_par_en,
    input  logic [NREQ-1:0]   req_par_ty,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              par_en,
    output logic              par_ty,
    input  logic              tx_busy,
    output logic [IDW-1:0]    grant_id,
    output logic              arb_busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int TOW = $clog2(START_TIMEOUT) + 1;
    localparam int GPW = $clog2(GAP_CYCLES) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic [GPW-1:0] gap_cnt_q, gap_cnt_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [7:0]     data_q, data_d;
    logic           pe_q, pe_d;
    logic           pt_q, pt_d;
    logic           done_q, done_d;
    logic           tmo_q, tmo_d;

    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           found;
    logic           accept;

    // Search starts just past the last grant and wraps.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IDW'((int'(last_q) + i) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign accept = (state_q == S_IDLE) && found && !tx_busy;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        to_cnt_d  = '0;
        gap_cnt_d = '0;
        last_d    = last_q;
        grant_d   = grant_q;
        data_d    = data_q;
        pe_d      = pe_q;
        pt_d      = pt_q;
        done_d    = 1'b0;
        tmo_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d  = req_data[{win, 3'b000} +: 8];
                    pe_d    = req_par_en[win];
                    pt_d    = req_par_ty[win];
                    grant_d = win;
                    last_d  = win;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tx_busy) begin
                    state_d = S_WAIT;
                end else if (to_cnt_q == TOW'(START_TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (!tx_busy) begin
                    done_d  = 1'b1;
                    state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GPW'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            last_q    <= IDW'(NREQ - 1);
            grant_q   <= '0;
            data_q    <= '0;
            pe_q      <= 1'b0;
            pt_q      <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            pe_q      <= pe_d;
            pt_q      <= pt_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
        end
    end

    assign tx_start    = (state_q == S_START);
    assign tx_data     = data_q;
    assign par_en      = pe_q;
    assign par_ty      = pt_q;
    assign grant_id    = grant_q;
    assign arb_busy    = (state_q != S_IDLE);
    assign done        = done_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the transmitter's busy flag is
// driven by the bench to emulate frames of a fixed length.
module tb_uart_tx_arbiter;

    localparam int LEN = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_par_en;
    logic [3:0]  req_par_ty;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        par_en;
    logic        par_ty;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        done;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    uart_tx_arbiter #(
        .NREQ(4),
        .START_TIMEOUT(64),
        .GAP_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_par_en(req_par_en),
        .req_par_ty(req_par_ty),
        .req_ready(req_ready),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .par_en(par_en),
        .par_ty(par_ty),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .arb_busy(arb_busy),
        .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        req_par_en = '0;
        req_par_ty = '0;
        tx_busy    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Emulates one transmitter frame; returns what was latched and whether
    // done followed.
    task automatic serve(input int len, output bit ok, output logic [7:0] d,
                         output logic pe, output logic pt,
                         output logic [1:0] gid, output bit stable,
                         output int t0);
        ok = 1'b0; stable = 1'b1; d = '0; pe = 1'b0; pt = 1'b0;
        gid = '0; t0 = 0;
        for (int i = 0; i < 200 && tx_start !== 1'b1; i++) tick();
        if (tx_start !== 1'b1) return;
        t0 = cyc; d = tx_data; pe = par_en; pt = par_ty;
        tx_busy = 1'b1;
        tick();
        for (int i = 0; i < len; i++) begin
            if ({tx_data, par_en, par_ty} !== {d, pe, pt} || tx_start !== 1'b0)
                stable = 1'b0;
            tick();
        end
        tx_busy = 1'b0;
        tick();
        ok  = (done === 1'b1);
        gid = grant_id;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({req_ready, tx_start, tx_data, par_en, par_ty} !== 14'd0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0",
                     {req_ready, tx_start, tx_data, par_en, par_ty});
        end
        checks++;
        if ({grant_id, arb_busy, done, timeout_err} !== 5'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {grant_id, arb_busy, done, timeout_err});
        end
    endtask

    task automatic test_single();
        bit bad;
        logic [7:0] hold;
        do_reset();
        req_valid = 4'b0001; req_data[7:0] = 8'hAF;
        req_par_en = 4'b0001; req_par_ty = 4'b0000;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_ready got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if ({tx_start, tx_data, par_en, par_ty, arb_busy, req_ready} !==
            {1'b1, 8'hAF, 1'b1, 1'b0, 1'b1, 4'b0000}) begin
            failures++;
            $display("FAIL single_latch got=%b%h%b%b%b%b exp=1af1010000",
                     tx_start, tx_data, par_en, par_ty, arb_busy, req_ready);
        end
        tick(); tick();
        checks++;
        if (tx_start !== 1'b1) begin
            failures++;
            $display("FAIL single_start_hold got=%b exp=1", tx_start);
        end
        tx_busy = 1'b1;
        tick();
        checks++;
        if (tx_start !== 1'b0 || arb_busy !== 1'b1) begin
            failures++;
            $display("FAIL single_start_drop got=%b%b exp=01", tx_start, arb_busy);
        end
        hold = tx_data; bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (tx_data !== hold || done !== 1'b0) bad = 1'b1;
            tick();
        end
        tx_busy = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1 || grant_id !== 2'd0 || bad) begin
            failures++;
            $display("FAIL single_done got=%b/%0d/%b exp=1/0/0", done, grant_id, bad);
        end
        req_valid = 4'b0001; req_data[7:0] = 8'h5A;
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (req_ready !== 4'b0000 || arb_busy !== 1'b1) bad = 1'b1;
            if (i > 0 && done !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL gap_hold got=early_grant exp=no_grant");
        end
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL gap_end_ready got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (tx_data !== 8'h5A) begin
            failures++;
            $display("FAIL single_second got=%h exp=5a", tx_data);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        bit ok, st;
        logic [7:0] d;
        logic pe, pt;
        logic [1:0] g;
        int t0, tprev;
        do_reset();
        req_valid = 4'b1111; req_data = 32'h13121110;
        tprev = 0;
        for (int k = 0; k < 5; k++) begin
            serve(LEN, ok, d, pe, pt, g, st, t0);
            checks++;
            if (!ok || !st || d !== exp_d[k] || g !== exp_g[k]) begin
                failures++;
                $display("FAIL rr_frame%0d got=%h/%0d ok=%b st=%b exp=%h/%0d",
                         k, d, g, ok, st, exp_d[k], exp_g[k]);
            end
            if (k > 0) begin
                checks++;
                if (t0 - tprev != LEN + 19) begin
                    failures++;
                    $display("FAIL rr_spacing%0d got=%0d exp=%0d",
                             k, t0 - tprev, LEN + 19);
                end
            end
            tprev = t0;
        end
    endtask

    task automatic test_fairness();
        bit ok, st;
        logic [7:0] d;
        logic pe, pt;
        logic [1:0] g;
        int t0;
        do_reset();
        req_valid = 4'b0001; req_data = 32'h00A200A0;
        for (int i = 0; i < 20 && tx_start !== 1'b1; i++) tick();
        req_valid = 4'b0101;
        serve(LEN, ok, d, pe, pt, g, st, t0);
        checks++;
        if (!ok || g !== 2'd0 || d !== 8'hA0) begin
            failures++;
            $display("FAIL fair_first got=%h/%0d ok=%b exp=a0/0", d, g, ok);
        end
        serve(LEN, ok, d, pe, pt, g, st, t0);
        checks++;
        if (!ok || g !== 2'd2 || d !== 8'hA2) begin
            failures++;
            $display("FAIL fair_second got=%h/%0d ok=%b exp=a2/2", d, g, ok);
        end
        serve(LEN, ok, d, pe, pt, g, st, t0);
        checks++;
        if (!ok || g !== 2'd0 || d !== 8'hA0) begin
            failures++;
            $display("FAIL fair_third got=%h/%0d ok=%b exp=a0/0", d, g, ok);
        end
    endtask

    task automatic test_parity();
        bit ok, st;
        logic [7:0] d;
        logic pe, pt;
        logic [1:0] g;
        int t0;
        do_reset();
        req_valid = 4'b1010; req_data = 32'h55003C00;
        req_par_en = 4'b0010; req_par_ty = 4'b1010;
        serve(LEN, ok, d, pe, pt, g, st, t0);
        checks++;
        if (!ok || !st || d !== 8'h3C || {pe, pt} !== 2'b11 || g !== 2'd1) begin
            failures++;
            $display("FAIL par_req1 got=%h pe=%b pt=%b g=%0d st=%b exp=3c/1/1/1/1",
                     d, pe, pt, g, st);
        end
        serve(LEN, ok, d, pe, pt, g, st, t0);
        checks++;
        if (!ok || !st || d !== 8'h55 || pe !== 1'b0 || g !== 2'd3) begin
            failures++;
            $display("FAIL par_req3 got=%h pe=%b g=%0d st=%b exp=55/0/3/1",
                     d, pe, g, st);
        end
    endtask

    task automatic test_timeout();
        bit bad;
        do_reset();
        req_valid = 4'b0011; req_data = 32'h00000201;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL tmo_accept got=%b exp=0001", req_ready);
        end
        tick();
        bad = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (tx_start !== 1'b1 || timeout_err !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL tmo_window got=early_drop exp=64_start_cycles");
        end
        checks++;
        if ({timeout_err, tx_start, arb_busy, req_ready} !== 7'b1000010) begin
            failures++;
            $display("FAIL tmo_pulse got=%b%b%b%b exp=1000010",
                     timeout_err, tx_start, arb_busy, req_ready);
        end
        tick();
        checks++;
        if ({timeout_err, tx_start, tx_data, grant_id} !== {2'b01, 8'h02, 2'd1}) begin
            failures++;
            $display("FAIL tmo_next got=%b%b/%h/%0d exp=01/02/1",
                     timeout_err, tx_start, tx_data, grant_id);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        bit bad;
        do_reset();
        req_valid = 4'b0010; req_data = 32'h00007766;
        for (int i = 0; i < 20 && tx_start !== 1'b1; i++) tick();
        tx_busy = 1'b1;
        tick(); tick();
        checks++;
        if (arb_busy !== 1'b1 || grant_id !== 2'd1 || tx_data !== 8'h77) begin
            failures++;
            $display("FAIL rst_pre got=%b/%0d/%h exp=1/1/77", arb_busy, grant_id, tx_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({tx_start, arb_busy, grant_id, tx_data} !== 12'd0) begin
            failures++;
            $display("FAIL rst_mid got=%b%b/%0d/%h exp=00/0/00",
                     tx_start, arb_busy, grant_id, tx_data);
        end
        req_valid = 4'b0011;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (req_ready !== 4'b0000 || arb_busy !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL rst_busy_block got=grant exp=no_grant");
        end
        tx_busy = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rst_first_win got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (tx_data !== 8'h66 || tx_start !== 1'b1) begin
            failures++;
            $display("FAIL rst_after got=%h/%b exp=66/1", tx_data, tx_start);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_parity();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
